// File: rtl/sim_run_controller.sv
// Run controller for a processor-under-test: pulses the core reset, counts run cycles,
// snoops data-memory stores into a small log and ends the run with PASS/FAIL/TIMEOUT.
module sim_run_controller #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 200,
    parameter logic [31:0] TOHOST_ADR   = 32'h0000_0100,
    parameter logic [31:0] PASS_VALUE   = 32'h0000_0001,
    parameter bit          HALT_ON_DONE = 1'b1,
    parameter int unsigned LOG_DEPTH    = 8,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned LOG_AW      = $clog2(LOG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count,
    input  logic [LOG_AW-1:0] log_idx,
    output logic [31:0]       log_adr,
    output logic [31:0]       log_data,
    output logic              log_valid,
    output logic [1:0]        fsm_state
);
    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                core_reset_q, core_reset_d;
    logic [1:0]          status_q, status_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    store_q, store_d;
    logic [LOG_AW-1:0]   wptr_q;
    logic                log_we;
    logic [31:0]         log_adr_mem  [LOG_DEPTH];
    logic [31:0]         log_data_mem [LOG_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HOLD;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            status_q     <= 2'b00;
            cycle_q      <= '0;
            store_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
            status_q     <= status_d;
            cycle_q      <= cycle_d;
            store_q      <= store_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        core_reset_d = core_reset_q;
        status_d     = status_q;
        cycle_d      = cycle_q;
        store_d      = store_q;
        log_we       = 1'b0;
        case (state_q)
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d      = RUN;
                    core_reset_d = 1'b0;
                end
            end
            RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
                if (MemWrite) begin
                    log_we = 1'b1;
                    if (store_q != '1) store_d = store_q + 1'b1;
                end
                // A tohost store on the limit edge takes priority over the timeout.
                if (MemWrite && (DataAdr == TOHOST_ADR)) begin
                    state_d      = DONE;
                    status_d     = (WriteData == PASS_VALUE) ? 2'b01 : 2'b10;
                    core_reset_d = HALT_ON_DONE;
                end else if (cycle_d >= CNT_W'(MAX_CYCLES)) begin
                    state_d      = DONE;
                    status_d     = 2'b11;
                    core_reset_d = HALT_ON_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) begin
                log_adr_mem[i]  <= '0;
                log_data_mem[i] <= '0;
            end
        end else if (log_we) begin
            log_adr_mem[wptr_q]  <= DataAdr;
            log_data_mem[wptr_q] <= WriteData;
            wptr_q               <= wptr_q + 1'b1;
        end
    end

    // Index 0 is the newest entry; the pointer arithmetic wraps at LOG_DEPTH.
    logic [LOG_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]  filled;

    always_comb begin
        rd_ptr    = wptr_q - LOG_AW'(1) - log_idx;
        filled    = (store_q < CNT_W'(LOG_DEPTH)) ? store_q : CNT_W'(LOG_DEPTH);
        log_valid = (CNT_W'(log_idx) < filled);
        log_adr   = log_valid ? log_adr_mem[rd_ptr]  : 32'h0;
        log_data  = log_valid ? log_data_mem[rd_ptr] : 32'h0;
    end

    assign core_reset  = core_reset_q;
    assign running     = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign status      = status_q;
    assign cycle_count = cycle_q;
    assign store_count = store_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: table-driven store/log vectors plus
// hand-written sequences for reset release, tohost termination, timeout and mid-run reset.
module tb_sim_run_controller;
    localparam int LOG_DEPTH = 4;
    localparam int CNT_W     = 32;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        core_reset;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] store_count;
    logic [1:0]  log_idx;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic        log_valid;
    logic [1:0]  fsm_state;

    int n_vec  = 0;
    int n_miss = 0;

    sim_run_controller #(
        .RESET_CYCLES(4),
        .MAX_CYCLES  (200),
        .TOHOST_ADR  (32'h0000_0100),
        .PASS_VALUE  (32'h0000_0001),
        .HALT_ON_DONE(1'b1),
        .LOG_DEPTH   (LOG_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .status     (status),
        .cycle_count(cycle_count),
        .store_count(store_count),
        .log_idx    (log_idx),
        .log_adr    (log_adr),
        .log_data   (log_data),
        .log_valid  (log_valid),
        .fsm_state  (fsm_state)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] data;
        logic [1:0]  idx;
        logic [31:0] exp_cc;
        logic [31:0] exp_sc;
        logic        exp_valid;
        logic [31:0] exp_adr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = data;
    endtask

    // Pulse reset away from the clock edge, then step through the 4 hold edges.
    task automatic start_run(input string tag);
        drive(1'b0, 32'h0, 32'h0);
        log_idx = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        repeat (3) tick();
        check({tag, " hold core_reset"}, 32'(core_reset), 32'd1);
        tick();
        check({tag, " run entry"}, {30'd0, running, core_reset}, 32'b10);
        check({tag, " run entry cc"}, cycle_count, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'h1010, 2'd0, 32'd1,  32'd1, 1'b1, 32'h10, 32'h1010};
        vecs[1] = '{1'b1, 32'h20, 32'h1020, 2'd2, 32'd2,  32'd2, 1'b0, 32'h0,  32'h0};
        vecs[2] = '{1'b0, 32'h0,  32'h0,    2'd1, 32'd3,  32'd2, 1'b1, 32'h10, 32'h1010};
        vecs[3] = '{1'b1, 32'h30, 32'h1030, 2'd0, 32'd4,  32'd3, 1'b1, 32'h30, 32'h1030};
        vecs[4] = '{1'b1, 32'h40, 32'h1040, 2'd3, 32'd5,  32'd4, 1'b1, 32'h10, 32'h1010};
        vecs[5] = '{1'b1, 32'h50, 32'h1050, 2'd3, 32'd6,  32'd5, 1'b1, 32'h20, 32'h1020};
        vecs[6] = '{1'b1, 32'h60, 32'h1060, 2'd0, 32'd7,  32'd6, 1'b1, 32'h60, 32'h1060};
        vecs[7] = '{1'b0, 32'h0,  32'h0,    2'd3, 32'd8,  32'd6, 1'b1, 32'h30, 32'h1030};
        vecs[8] = '{1'b0, 32'h0,  32'h0,    2'd1, 32'd9,  32'd6, 1'b1, 32'h50, 32'h1050};
        vecs[9] = '{1'b0, 32'h0,  32'h0,    2'd2, 32'd10, 32'd6, 1'b1, 32'h40, 32'h1040};

        // Reset state and core reset release (release at t=22, edges 25/35/45/55)
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        log_idx = 2'd0;
        #1 reset = 1'b0;
        #1;
        check("reset core_reset", 32'(core_reset), 32'd1);
        check("reset flags", {29'd0, running, done, status != 2'b00}, 32'd0);
        check("reset cycle_count", cycle_count, 32'd0);
        check("reset store_count", store_count, 32'd0);
        check("reset log_valid", 32'(log_valid), 32'd0);
        #20 reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("hold core_reset", {30'd0, running, core_reset}, 32'b01);
        end
        tick();
        check("t55 release", {30'd0, running, core_reset}, 32'b10);
        check("t55 time", 32'($time), 32'd56);

        // Tohost PASS on the 11th RUN edge
        for (int k = 1; k <= 10; k++) tick();
        check("pre-pass cc", cycle_count, 32'd10);
        drive(1'b1, 32'h100, 32'h1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("pass done/run/cr", {29'd0, done, running, core_reset}, 32'b101);
        check("pass status", 32'(status), 32'd1);
        check("pass cc", cycle_count, 32'd11);
        check("pass log_adr", log_adr, 32'h100);
        repeat (3) tick();
        check("pass cc frozen", cycle_count, 32'd11);

        // Tohost FAIL, then stores ignored in DONE
        start_run("fail");
        drive(1'b1, 32'h100, 32'hDEAD);
        tick();
        check("fail status", 32'(status), 32'd2);
        check("fail sc", store_count, 32'd1);
        drive(1'b1, 32'h100, 32'h1);
        repeat (3) tick();
        drive(1'b0, 32'h0, 32'h0);
        check("done sc frozen", store_count, 32'd1);
        check("done status frozen", 32'(status), 32'd2);
        check("done log frozen", log_data, 32'hDEAD);

        // Store log vectors
        start_run("log");
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].mw, vecs[i].adr, vecs[i].data);
            log_idx = vecs[i].idx;
            tick();
            check($sformatf("vec%0d cc", i), cycle_count, vecs[i].exp_cc);
            check($sformatf("vec%0d sc", i), store_count, vecs[i].exp_sc);
            check($sformatf("vec%0d valid", i), 32'(log_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d adr", i), log_adr, vecs[i].exp_adr);
            check($sformatf("vec%0d data", i), log_data, vecs[i].exp_data);
            check($sformatf("vec%0d running", i), 32'(running), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        log_idx = 2'd0;

        // Timeout on the 200th RUN edge
        start_run("tmo");
        repeat (199) tick();
        check("tmo edge199", {30'd0, running, done}, 32'b10);
        check("tmo cc199", cycle_count, 32'd199);
        tick();
        check("tmo done", {30'd0, running, done}, 32'b01);
        check("tmo status", 32'(status), 32'd3);
        check("tmo cc", cycle_count, 32'd200);
        check("tmo core_reset", 32'(core_reset), 32'd1);

        // PASS store on the limit edge beats timeout
        start_run("race");
        repeat (199) tick();
        drive(1'b1, 32'h100, 32'h1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("race status", 32'(status), 32'd1);
        check("race cc", cycle_count, 32'd200);

        // Reset dropped mid-run
        start_run("mid");
        repeat (48) tick();
        drive(1'b1, 32'h44, 32'h55);
        repeat (2) tick();
        drive(1'b0, 32'h0, 32'h0);
        check("mid cc50", cycle_count, 32'd50);
        check("mid sc2", store_count, 32'd2);
        #2 reset = 1'b0;
        #1;
        check("mid core_reset", 32'(core_reset), 32'd1);
        check("mid cc", cycle_count, 32'd0);
        check("mid sc", store_count, 32'd0);
        check("mid log_valid", 32'(log_valid), 32'd0);
        check("mid running", 32'(running), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        check("mid hold", {30'd0, running, core_reset}, 32'b01);
        tick();
        check("mid rerun", {30'd0, running, core_reset}, 32'b10);
        tick();
        check("mid rerun cc", cycle_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Safety net: the directed sequences finish far earlier than this.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
